// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the pipeline register chain
package pipe_pkg;

  localparam int PIPE_RIGID   = 0;
  localparam int PIPE_ELASTIC = 1;
  localparam int MAX_STAGES   = 8;

  function automatic logic [3:0] popcount(input logic [MAX_STAGES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_STAGES; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+data pipeline register with load, kill and hold
module pipe_slot #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         kill,
  input  logic         hold,
  input  logic [N-1:0] load_data,
  output logic         valid,
  output logic [N-1:0] data
);

  // A load always wins over kill: kill targets only the current occupant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= load | (hold & valid & ~kill);
      if (load) data <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// rtl/pipe_stage_chain.sv - parametrised ready/valid pipeline register chain
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter  int N      = 32,
  parameter  int STAGES = 2,
  parameter  int MODE   = PIPE_RIGID,
  localparam int CW     = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STAGES-1:0] flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic [CW-1:0]     count
);

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] live;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] src_live;
  logic [N-1:0]      data     [STAGES];
  logic [N-1:0]      src_data [STAGES];

  assign live = valid & ~flush;

  always_comb begin
    src_live    = '0;
    src_live[0] = in_valid;
    src_data[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      src_live[i] = live[i-1];
      src_data[i] = data[i-1];
    end
  end

  generate
    if (MODE == PIPE_ELASTIC) begin : g_elastic
      logic [STAGES-1:0] acc;
      logic [STAGES-1:0] move;

      // Accept chain ripples from the output end back to slot 0.
      always_comb begin
        acc  = '0;
        move = '0;
        move[STAGES-1] = live[STAGES-1] & out_ready;
        acc[STAGES-1]  = ~live[STAGES-1] | out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
          move[i] = live[i] & acc[i+1];
          acc[i]  = ~live[i] | move[i];
        end
      end

      assign load     = src_live & acc;
      assign hold     = ~move;
      assign in_ready = acc[0];
    end else begin : g_rigid
      logic en;

      assign en       = ~live[STAGES-1] | out_ready;
      assign load     = src_live & {STAGES{en}};
      assign hold     = {STAGES{~en}};
      assign in_ready = en;
    end
  endgenerate

  for (genvar g = 0; g < STAGES; g++) begin : g_slot
    pipe_slot #(.N(N)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[g]),
      .kill      (flush[g]),
      .hold      (hold[g]),
      .load_data (src_data[g]),
      .valid     (valid[g]),
      .data      (data[g])
    );
  end

  assign out_valid = live[STAGES-1];
  assign out_data  = data[STAGES-1];

  logic       in_fire;
  logic       out_fire;
  logic [3:0] killed;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign killed   = popcount(MAX_STAGES'(valid & flush));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count + CW'(in_fire) - CW'(out_fire) - CW'(killed);
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb/tb_pipe_stage_chain.sv - self-checking bench for pipe_stage_chain
module tb_pipe_stage_chain;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        r_in_ready, r_out_valid, e_in_ready, e_out_valid;
  logic [31:0] r_out_data, e_out_data;
  logic [1:0]  r_count, e_count;

  always #5 clk = ~clk;

  pipe_stage_chain #(.N(32), .STAGES(3), .MODE(PIPE_RIGID)) u_rigid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_data(in_data), .out_valid(r_out_valid), .out_ready(out_ready),
    .out_data(r_out_data), .count(r_count)
  );

  pipe_stage_chain #(.N(32), .STAGES(3), .MODE(PIPE_ELASTIC)) u_elastic (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_data(in_data), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_data(e_out_data), .count(e_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] qr[$];
  logic [31:0] qe[$];
  logic        kill_en;
  logic [31:0] kill_val;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        ov;
    logic [31:0] od;
    int          cnt;
    logic        ir;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard update at the sample point, using the inputs of the current cycle.
  task automatic sb_update();
    int idx;
    chk("r_count_vs_sb", 32'(r_count), qr.size());
    if (r_out_valid && out_ready) begin
      if (qr.size() == 0) chk("r_unexpected_out", 32'd1, 32'd0);
      else chk("r_out_data", r_out_data, qr.pop_front());
    end
    chk("e_count_vs_sb", 32'(e_count), qe.size());
    if (e_out_valid && out_ready) begin
      if (qe.size() == 0) chk("e_unexpected_out", 32'd1, 32'd0);
      else chk("e_out_data", e_out_data, qe.pop_front());
    end
    if (kill_en) begin
      idx = -1;
      foreach (qr[j]) if (idx < 0 && qr[j] == kill_val) idx = j;
      if (idx >= 0) qr.delete(idx);
      idx = -1;
      foreach (qe[j]) if (idx < 0 && qe[j] == kill_val) idx = j;
      if (idx >= 0) qe.delete(idx);
    end
    if (in_valid && r_in_ready) qr.push_back(in_data);
    if (in_valid && e_in_ready) qe.push_back(in_data);
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic adv();
    sb_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic [2:0] fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    kill_en = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 3'b000);
    qr.delete();
    qe.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 32'h00, 0, 1'b1};
    vecs[1] = '{1'b1, 32'h22, 1'b1, 1'b0, 32'h00, 1, 1'b1};
    vecs[2] = '{1'b1, 32'h33, 1'b1, 1'b0, 32'h00, 2, 1'b1};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h11, 3, 1'b1};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 2, 1'b1};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 1, 1'b1};
    vecs[6] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h33, 0, 1'b1};

    reset = 1'b1;
    kill_en = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    at_neg();
    chk("rst_r_out_valid", 32'(r_out_valid), 32'd0);
    chk("rst_r_out_data", r_out_data, 32'd0);
    chk("rst_r_count", 32'(r_count), 32'd0);
    chk("rst_r_in_ready", 32'(r_in_ready), 32'd1);
    chk("rst_e_in_ready", 32'(e_in_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Rigid stream, table driven
    for (int k = 0; k < 7; k++) begin
      drive(vecs[k].iv, vecs[k].d, vecs[k].ordy, 3'b000);
      at_neg();
      chk($sformatf("vec%0d_out_valid", k), 32'(r_out_valid), 32'(vecs[k].ov));
      chk($sformatf("vec%0d_out_data", k), r_out_data, vecs[k].od);
      chk($sformatf("vec%0d_count", k), 32'(r_count), vecs[k].cnt);
      chk($sformatf("vec%0d_in_ready", k), 32'(r_in_ready), 32'(vecs[k].ir));
      adv();
    end

    // Fill with out_ready low, then drain
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'hA0 + k, 1'b0, 3'b000);
      at_neg();
      chk("fill_e_in_ready", 32'(e_in_ready), 32'd1);
      adv();
    end
    drive(1'b1, 32'hA3, 1'b0, 3'b000);
    at_neg();
    chk("fill_e_in_ready_full", 32'(e_in_ready), 32'd0);
    chk("fill_e_count", 32'(e_count), 32'd3);
    chk("fill_r_in_ready_full", 32'(r_in_ready), 32'd0);
    adv();
    drive(1'b1, 32'hA3, 1'b1, 3'b000);
    at_neg();
    chk("fill_e_accept_on_drain", 32'(e_in_ready), 32'd1);
    adv();
    drive(1'b0, 32'h0, 1'b1, 3'b000);
    repeat (5) begin at_neg(); adv(); end
    chk("fill_e_drained", qe.size(), 32'd0);
    chk("fill_r_drained", qr.size(), 32'd0);

    // Rigid keeps bubble, elastic collapses it
    do_reset();
    drive(1'b1, 32'h5, 1'b1, 3'b000); at_neg(); adv();
    drive(1'b0, 32'h0, 1'b1, 3'b000); at_neg(); adv();
    drive(1'b1, 32'h6, 1'b1, 3'b000); at_neg(); adv();
    drive(1'b0, 32'h0, 1'b0, 3'b000);
    at_neg();
    chk("bub_r_count", 32'(r_count), 32'd2);
    chk("bub_r_in_ready", 32'(r_in_ready), 32'd0);
    chk("bub_e_count", 32'(e_count), 32'd2);
    chk("bub_e_in_ready", 32'(e_in_ready), 32'd1);
    adv();
    at_neg();
    chk("bub_r_in_ready_hold", 32'(r_in_ready), 32'd0);
    chk("bub_e_in_ready_hold", 32'(e_in_ready), 32'd1);
    chk("bub_r_out_data", r_out_data, 32'h5);
    adv();
    drive(1'b0, 32'h0, 1'b1, 3'b000);
    repeat (5) begin at_neg(); adv(); end
    chk("bub_drained", qr.size() + qe.size(), 32'd0);

    // Flush middle slot while output is taken
    do_reset();
    drive(1'b1, 32'h3, 1'b1, 3'b000); at_neg(); adv();
    drive(1'b1, 32'h2, 1'b1, 3'b000); at_neg(); adv();
    drive(1'b1, 32'h1, 1'b1, 3'b000); at_neg(); adv();
    drive(1'b0, 32'h0, 1'b1, 3'b010);
    kill_en = 1'b1; kill_val = 32'h2;
    at_neg();
    chk("fm_out_data", r_out_data, 32'h3);
    chk("fm_count_before", 32'(r_count), 32'd3);
    adv();
    kill_en = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 3'b000);
    at_neg();
    chk("fm_r_count_after", 32'(r_count), 32'd1);
    chk("fm_e_count_after", 32'(e_count), 32'd1);
    adv();
    at_neg();
    chk("fm_r_out_next", r_out_data, 32'h1);
    chk("fm_e_out_next", e_out_data, 32'h1);
    adv();
    repeat (3) begin at_neg(); adv(); end

    // Flush the output slot while out_ready is high
    do_reset();
    drive(1'b1, 32'h7, 1'b1, 3'b000); at_neg(); adv();
    drive(1'b0, 32'h0, 1'b1, 3'b000); at_neg(); adv();
    at_neg(); adv();
    drive(1'b0, 32'h0, 1'b1, 3'b100);
    kill_en = 1'b1; kill_val = 32'h7;
    at_neg();
    chk("fo_r_out_valid", 32'(r_out_valid), 32'd0);
    chk("fo_e_out_valid", 32'(e_out_valid), 32'd0);
    chk("fo_count_before", 32'(r_count), 32'd1);
    adv();
    kill_en = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 3'b000);
    at_neg();
    chk("fo_r_count_after", 32'(r_count), 32'd0);
    chk("fo_e_count_after", 32'(e_count), 32'd0);
    adv();

    // Reset while full and stalled
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hC0 + k, 1'b0, 3'b000); at_neg(); adv();
    end
    reset = 1'b1;
    #1;
    chk("mr_r_out_valid", 32'(r_out_valid), 32'd0);
    chk("mr_r_out_data", r_out_data, 32'd0);
    chk("mr_r_count", 32'(r_count), 32'd0);
    chk("mr_r_in_ready", 32'(r_in_ready), 32'd1);
    chk("mr_e_out_data", e_out_data, 32'd0);
    chk("mr_e_count", 32'(e_count), 32'd0);
    chk("mr_e_in_ready", 32'(e_in_ready), 32'd1);
    qr.delete();
    qe.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Random traffic, no flush
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0), 3'b000);
      at_neg();
      adv();
    end
    drive(1'b0, 32'h0, 1'b1, 3'b000);
    repeat (5) begin at_neg(); adv(); end
    chk("rand_r_drained", qr.size(), 32'd0);
    chk("rand_e_drained", qe.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
